// File: rtl/carry_skip_adder_8.sv
// 8-bit carry-skip adder: two 4-bit ripple groups, each with a group-propagate
// bypass mux on its carry-out, and a registered {Cout, Sum} boundary.
module carry_skip_adder_8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] Sum,
  output logic       Cout
);

  logic [7:0] p;
  logic [7:0] g;
  logic [4:0] c0;
  logic [4:0] c1;
  logic       grp0_p;
  logic       grp1_p;
  logic       grp0_cout;
  logic       grp1_cout;
  logic [7:0] sum_d;
  logic [7:0] sum_q;
  logic       cout_d;
  logic       cout_q;

  assign p = A ^ B;
  assign g = A & B;

  assign grp0_p = &p[3:0];
  assign grp1_p = &p[7:4];

  // Group 0 ripple chain, fed directly by Cin
  always_comb begin
    c0[0] = Cin;
    for (int i = 0; i < 4; i++) begin
      c0[i+1] = g[i] | (p[i] & c0[i]);
    end
  end

  // Inter-group carry must come from the skip mux so the critical path
  // from Cin bypasses the group 0 ripple when the group fully propagates.
  assign grp0_cout = grp0_p ? Cin : c0[4];

  always_comb begin
    c1[0] = grp0_cout;
    for (int i = 0; i < 4; i++) begin
      c1[i+1] = g[i+4] | (p[i+4] & c1[i]);
    end
  end

  assign grp1_cout = grp1_p ? grp0_cout : c1[4];

  always_comb begin
    sum_d  = 8'h00;
    for (int i = 0; i < 4; i++) begin
      sum_d[i]   = p[i]   ^ c0[i];
      sum_d[i+4] = p[i+4] ^ c1[i];
    end
    cout_d = grp1_cout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= 8'h00;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_carry_skip_adder_8.sv
// Randomized and directed check of carry_skip_adder_8 against an arithmetic
// reference model (A + B + Cin as a 9-bit value), one-cycle latency.
module tb_carry_skip_adder_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic [7:0] Sum;
  logic       Cout;

  int n_cmp;
  int n_err;
  logic [8:0] exp_res;

  carry_skip_adder_8 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .Sum  (Sum),
    .Cout (Cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got {Cout,Sum}=%03h expected %03h (A=%02h B=%02h Cin=%0b)",
               tag, obs, exp, A, B, Cin);
    end
  endtask

  function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b,
                                         input logic ci);
    int total;
    total = int'(a) + int'(b) + int'(ci);
    return total[8:0];
  endfunction

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic ci);
    @(negedge clk);
    A = a;
    B = b;
    Cin = ci;
    exp_res = ref_add(a, b, ci);
  endtask

  task automatic step_chk(input string tag);
    @(posedge clk);
    #1;
    chk(tag, {Cout, Sum}, exp_res);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    n_cmp = 0;
    n_err = 0;

    // Reset held with live inputs: outputs must stay zero
    rst_n = 1'b0;
    A = 8'hFF;
    B = 8'h01;
    Cin = 1'b1;
    exp_res = 9'h000;
    #1;
    chk("rst_async", {Cout, Sum}, 9'h000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold", {Cout, Sum}, 9'h000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release", {Cout, Sum}, 9'h101);

    drive(8'h01, 8'h01, 1'b0); step_chk("add_1_1");
    chk("add_1_1_const", {Cout, Sum}, 9'h002);
    drive(8'hFF, 8'h01, 1'b0); step_chk("add_ff_1");
    chk("add_ff_1_const", {Cout, Sum}, 9'h100);
    drive(8'hAA, 8'h55, 1'b1); step_chk("skip_cin1");
    chk("skip_cin1_const", {Cout, Sum}, 9'h100);
    drive(8'hAA, 8'h55, 1'b0); step_chk("skip_cin0");
    chk("skip_cin0_const", {Cout, Sum}, 9'h0FF);
    drive(8'hFF, 8'hFF, 1'b1); step_chk("max");
    chk("max_const", {Cout, Sum}, 9'h1FF);
    drive(8'h00, 8'h00, 1'b0); step_chk("zero_b2b");
    chk("zero_b2b_const", {Cout, Sum}, 9'h000);

    // Inputs changing between edges must not disturb the registered result
    drive(8'h3C, 8'h4B, 1'b1); step_chk("hold_pre");
    #2;
    A = 8'hF0;
    B = 8'h0F;
    Cin = 1'b0;
    #1;
    chk("hold_between_edges", {Cout, Sum}, 9'h088);

    // Mid-stream reset pulse shorter than a cycle
    drive(8'h12, 8'h34, 1'b0); step_chk("pre_pulse");
    @(negedge clk);
    A = 8'h80;
    B = 8'h80;
    Cin = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("pulse_async_clear", {Cout, Sum}, 9'h000);
    #1;
    rst_n = 1'b1;
    #1;
    chk("pulse_still_clear", {Cout, Sum}, 9'h000);
    @(posedge clk);
    #1;
    chk("pulse_reload", {Cout, Sum}, 9'h101);

    // All-propagate operands: both groups skip, Cout mirrors Cin
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      rc = 1'($urandom);
      drive(ra, ~ra, rc);
      step_chk("allprop_model");
      chk("allprop_cout", {Cout, 8'h00}, {rc, 8'h00});
    end

    // Group-0-only propagate with random upper nibble
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      rb = {4'($urandom), ~ra[3:0]};
      rc = 1'($urandom);
      drive(ra, rb, rc);
      step_chk("grp0_skip");
    end

    // Random stream, one operation per cycle
    for (int i = 0; i < 4000; i++) begin
      drive(8'($urandom), 8'($urandom), 1'($urandom));
      step_chk("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
